// File: rtl/go_routines.sv
// go_routines: two memory-reducing workers f (s0 -> a) and g (s1 -> b) plus launcher h.
// Ports: clk/reset (sync, active-high); a_*/b_* host register access; s0_*/s1_* host
// memory ports (registered dout, 1-cycle latency); *_req start requests; *_busy status.
// Build option: GOROUTINES_PIPELINED_READ_EN issues one read per cycle in the workers.

module go_routines_worker #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      addr,
    input  logic             we,
    input  logic             oe,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] IDLE = 3'd0, INIT = 3'd1, READ = 3'd2, ACC = 3'd3, DONE = 3'd4;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] acc_q, acc_d, rd_q, rd_d, dout_q, dout_d;
    logic             in_rng, host_we, last;
    always_comb begin
        in_rng  = addr < 32'(DEPTH);
        host_we = we && in_rng && !busy;
        dout_d  = (oe && !busy) ? (in_rng ? mem[addr[AW-1:0]] : '0) : dout_q;
        rd_d    = mem[i_q];
        last    = i_q == AW'(DEPTH - 1);
        state_d = state_q;
        i_d     = i_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: state_d = start ? INIT : IDLE;
            INIT: begin
                acc_d   = '0;
                i_d     = '0;
                state_d = READ;
            end
`ifdef GOROUTINES_PIPELINED_READ_EN
            // rd_q holds the word addressed last cycle; nothing is in flight at i==0
            READ: begin
                acc_d   = acc_q + ((i_q != '0) ? rd_q : '0);
                i_d     = last ? i_q : i_q + AW'(1);
                state_d = last ? ACC : READ;
            end
            ACC: begin
                acc_d   = acc_q + rd_q;
                state_d = DONE;
            end
`else
            READ: state_d = ACC;
            ACC: begin
                acc_d   = acc_q + rd_q;
                i_d     = last ? i_q : i_q + AW'(1);
                state_d = last ? DONE : READ;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (host_we) mem[addr[AW-1:0]] <= din;
        rd_q <= rd_d;
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
        end
    end
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign res  = acc_q;
    assign dout = dout_q;
endmodule

module go_routines #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_in,
    input  logic             a_we,
    output logic [WIDTH-1:0] a_out,
    input  logic [WIDTH-1:0] b_in,
    input  logic             b_we,
    output logic [WIDTH-1:0] b_out,
    input  logic [31:0]      s0_address,
    input  logic             s0_we,
    input  logic             s0_oe,
    input  logic [WIDTH-1:0] s0_din,
    output logic [WIDTH-1:0] s0_dout,
    output logic [31:0]      s0_length,
    input  logic [31:0]      s1_address,
    input  logic             s1_we,
    input  logic             s1_oe,
    input  logic [WIDTH-1:0] s1_din,
    output logic [WIDTH-1:0] s1_dout,
    output logic [31:0]      s1_length,
    input  logic             f_req,
    input  logic             g_req,
    input  logic             h_req,
    output logic             f_busy,
    output logic             g_busy,
    output logic             h_busy
);
    localparam logic [1:0] H_IDLE = 2'd0, H_START = 2'd1, H_WAIT = 2'd2;
    logic [1:0]       h_state_q, h_state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_res, g_res;
    logic             f_done, g_done, h_go;
    go_routines_worker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_f (
        .clk(clk), .reset(reset), .start(f_req || h_go),
        .addr(s0_address), .we(s0_we), .oe(s0_oe), .din(s0_din), .dout(s0_dout),
        .busy(f_busy), .done(f_done), .res(f_res)
    );
    go_routines_worker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_g (
        .clk(clk), .reset(reset), .start(g_req || h_go),
        .addr(s1_address), .we(s1_we), .oe(s1_oe), .din(s1_din), .dout(s1_dout),
        .busy(g_busy), .done(g_done), .res(g_res)
    );
    always_comb begin
        h_go      = h_state_q == H_START;
        h_state_d = (h_state_q == H_IDLE)  ? (h_req ? H_START : H_IDLE) :
                    (h_state_q == H_START) ? H_WAIT :
                    (f_busy || g_busy)     ? H_WAIT : H_IDLE;
        // a routine's result write takes priority over a same-cycle host write
        a_d = f_done ? f_res : a_we ? a_in : a_q;
        b_d = g_done ? g_res : b_we ? b_in : b_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            h_state_q <= H_IDLE;
            a_q       <= '0;
            b_q       <= '0;
        end else begin
            h_state_q <= h_state_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end
    assign h_busy    = h_state_q != H_IDLE;
    assign a_out     = a_q;
    assign b_out     = b_q;
    assign s0_length = 32'(DEPTH);
    assign s1_length = 32'(DEPTH);
endmodule

// File: tb/tb_go_routines.sv
// tb_go_routines: directed stimulus with a cycle-level behavioural model and literal checks.
module tb_go_routines;
    localparam int D = 16;
`ifdef GOROUTINES_PIPELINED_READ_EN
    localparam int FL = D + 3, HL = D + 5;
`else
    localparam int FL = 2 * D + 2, HL = 2 * D + 4;
`endif
    logic        clk = 0, reset = 1;
    logic [31:0] a_in = 0, b_in = 0, a_out, b_out;
    logic        a_we = 0, b_we = 0;
    logic [31:0] s0_address = 0, s1_address = 0, s0_din = 0, s1_din = 0;
    logic [31:0] s0_dout, s1_dout, s0_length, s1_length;
    logic        s0_we = 0, s0_oe = 0, s1_we = 0, s1_oe = 0;
    logic        f_req = 0, g_req = 0, h_req = 0, f_busy, g_busy, h_busy;
    int          n_tests = 0, n_fail = 0;
    bit          chk_en = 0;

    always #5 clk = ~clk;

    go_routines dut (
        .clk(clk), .reset(reset),
        .a_in(a_in), .a_we(a_we), .a_out(a_out),
        .b_in(b_in), .b_we(b_we), .b_out(b_out),
        .s0_address(s0_address), .s0_we(s0_we), .s0_oe(s0_oe), .s0_din(s0_din),
        .s0_dout(s0_dout), .s0_length(s0_length),
        .s1_address(s1_address), .s1_we(s1_we), .s1_oe(s1_oe), .s1_din(s1_din),
        .s1_dout(s1_dout), .s1_length(s1_length),
        .f_req(f_req), .g_req(g_req), .h_req(h_req),
        .f_busy(f_busy), .g_busy(g_busy), .h_busy(h_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each routine is a countdown of its busy length; the result lands when it expires.
    logic [31:0] m0 [D], m1 [D];
    logic [31:0] ea = 0, eb = 0, ed0 = 0, ed1 = 0;
    int          fc = 0, gc = 0, fc0, gc0;
    bit          hact = 0, hst = 0;

    function automatic logic [31:0] msum(input logic [31:0] m [D]);
        logic [31:0] s = 0;
        for (int k = 0; k < D; k++) s += m[k];
        return s;
    endfunction

    function automatic bit rng(input logic [31:0] adr);
        return $signed(adr) >= 0 && $signed(adr) < D;
    endfunction

    always @(posedge clk) begin
        fc0 = fc;
        gc0 = gc;
        if (reset) begin
            fc = 0; gc = 0; hact = 0; hst = 0;
            ea = 0; eb = 0; ed0 = 0; ed1 = 0;
        end else begin
            if (fc0 == 1) ea = msum(m0);
            else if (a_we) ea = a_in;
            if (gc0 == 1) eb = msum(m1);
            else if (b_we) eb = b_in;
            if (fc0 == 0) begin
                if (s0_oe) ed0 = rng(s0_address) ? m0[s0_address[3:0]] : 0;
                if (s0_we && rng(s0_address)) m0[s0_address[3:0]] = s0_din;
            end
            if (gc0 == 0) begin
                if (s1_oe) ed1 = rng(s1_address) ? m1[s1_address[3:0]] : 0;
                if (s1_we && rng(s1_address)) m1[s1_address[3:0]] = s1_din;
            end
            fc = fc0 > 0 ? fc0 - 1 : ((f_req || hst) ? FL : 0);
            gc = gc0 > 0 ? gc0 - 1 : ((g_req || hst) ? FL : 0);
            if (hst) hst = 0;
            else if (hact && fc0 == 0 && gc0 == 0) hact = 0;
            else if (!hact && h_req) begin hact = 1; hst = 1; end
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("m_a_out", a_out, ea);
        chk("m_b_out", b_out, eb);
        chk("m_s0_dout", s0_dout, ed0);
        chk("m_s1_dout", s1_dout, ed1);
        chk("m_f_busy", 32'(f_busy), 32'(fc > 0));
        chk("m_g_busy", 32'(g_busy), 32'(gc > 0));
        chk("m_h_busy", 32'(h_busy), 32'(hact));
    end

    task automatic wait_idle();
        int n = 0;
        while ((f_busy || g_busy || h_busy) && n < 200) begin n++; @(negedge clk); end
        chk("idle_timeout", 32'(n < 200), 1);
    endtask

    task automatic pulse_reset();
        reset = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic rd(input int adr, input logic [31:0] e0, input logic [31:0] e1);
        s0_address = adr; s1_address = adr; s0_oe = 1; s1_oe = 1;
        @(negedge clk);
        s0_oe = 0; s1_oe = 0;
        chk("rd_s0", s0_dout, e0);
        chk("rd_s1", s1_dout, e1);
    endtask

    initial begin
        int n;
        @(negedge clk);
        chk_en = 1;
        chk("rst_a", a_out, 0);
        chk("rst_busy", {29'd0, f_busy, g_busy, h_busy}, 0);
        chk("s0_length", s0_length, 16);
        reset = 0;
        for (int i = 0; i < D; i++) begin
            s0_address = i; s1_address = i; s0_din = i + 1; s1_din = i + 1;
            s0_we = 1; s1_we = 1;
            @(negedge clk);
        end
        s0_we = 0; s1_we = 0;
        // launcher runs both workers
        h_req = 1;
        @(negedge clk);
        h_req = 0;
        chk("h_rise", 32'(h_busy), 1);
        n = 0;
        while (h_busy && n < 200) begin n++; @(negedge clk); end
        chk("h_len", n, HL);
        chk("h_a", a_out, 136);
        chk("h_b", b_out, 136);
        // f alone
        pulse_reset();
        f_req = 1;
        @(negedge clk);
        f_req = 0;
        n = 0;
        while (f_busy && n < 200) begin n++; @(negedge clk); end
        chk("f_len", n, FL);
        chk("f_a", a_out, 136);
        chk("f_b", b_out, 0);
        // host write dropped while f busy
        f_req = 1;
        @(negedge clk);
        f_req = 0;
        s0_address = 3; s0_din = 5; s0_we = 1;
        @(negedge clk);
        s0_we = 0;
        wait_idle();
        rd(3, 4, 4);
        rd(32'hFFFF_FFFF, 0, 0);
        rd(16, 0, 0);
        // result write beats same-cycle host write
        f_req = 1;
        @(negedge clk);
        f_req = 0;
        repeat (FL - 1) @(negedge clk);
        a_in = 9; a_we = 1;
        @(negedge clk);
        a_we = 0;
        chk("a_collide", a_out, 136);
        a_we = 1;
        @(negedge clk);
        a_we = 0;
        chk("a_host", a_out, 9);
        // wrap-around
        for (int i = 0; i < D; i++) begin
            s0_address = i; s0_din = 32'h7FFF_FFFF; s0_we = 1;
            @(negedge clk);
        end
        s0_we = 0;
        f_req = 1;
        @(negedge clk);
        f_req = 0;
        wait_idle();
        chk("wrap", a_out, 32'hFFFF_FFF0);
        // reset mid-run
        h_req = 1;
        @(negedge clk);
        h_req = 0;
        repeat (10) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("mid_busy", {29'd0, f_busy, g_busy, h_busy}, 0);
        chk("mid_a", a_out, 0);
        chk("mid_b", b_out, 0);
        reset = 0;
        for (int i = 0; i < D; i++) rd(i, 32'h7FFF_FFFF, i + 1);
        chk("s1_length", s1_length, 16);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
